// File: rtl/reorder_tag_scheduler.sv
// Purpose : allocates reorder tags round-robin, records per-tag core verdicts, reports head status, reclaims tags.
// Latency : grant is combinational; verdicts and reclaims take effect on the next clk edge.
// Backpr. : alloc_gnt is withheld while every tag is outstanding; optional macro REORDER_TIMEOUT_EN adds a head-of-line watchdog.
module reorder_tag_scheduler #(
    parameter int TAG_WIDTH      = 6,
    parameter int NUM_TAGS       = 50,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 verdict_valid,
    input  logic [TAG_WIDTH-1:0] verdict_tag,
    input  logic                 verdict_accept,
    input  logic [TAG_WIDTH-1:0] buf_tag,
    output logic [1:0]           packet_status,
    output logic [TAG_WIDTH:0]   outstanding,
    output logic                 full,
    output logic                 empty,
    output logic                 err,
    input  logic                 err_clr,
    output logic                 timeout_evt
);

    // Encoding matches what circular_buffer expects on packet_status.
    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_REJECT  = 2'b01,
        ST_PENDING = 2'b10,
        ST_ACCEPT  = 2'b11
    } tag_state_t;

    localparam logic [TAG_WIDTH:0]   NUM_TAGS_W = (TAG_WIDTH+1)'(NUM_TAGS);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG   = TAG_WIDTH'(NUM_TAGS - 1);
    localparam logic [TAG_WIDTH:0]   ONE_CNT    = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH-1:0] ONE_TAG    = TAG_WIDTH'(1);

    tag_state_t           state     [NUM_TAGS];
    tag_state_t           state_nxt [NUM_TAGS];
    logic [TAG_WIDTH-1:0] alloc_ptr;
    logic [TAG_WIDTH-1:0] head_prev;

    logic       buf_in_range;
    tag_state_t head_state;
    logic       verdict_in_range;
    tag_state_t verdict_cur;
    logic       verdict_ok;
    logic       verdict_err;
    logic       head_chg;
    logic       prev_in_range;
    tag_state_t prev_state;
    logic       reclaim;
    logic       reclaim_err;
    logic       to_fire;

    // Occupancy decode and allocation handshake.
    assign full      = (outstanding == NUM_TAGS_W);
    assign empty     = (outstanding == '0);
    assign alloc_gnt = alloc_req & ~full;
    assign alloc_tag = alloc_ptr;

    // Head status: tags beyond the configured space read as FREE (wait).
    assign buf_in_range  = ({1'b0, buf_tag} < NUM_TAGS_W);
    assign head_state    = buf_in_range ? state[buf_tag] : ST_FREE;
    assign packet_status = head_state;

    // A verdict lands only on a PENDING in-range tag that is not being re-granted right now.
    assign verdict_in_range = ({1'b0, verdict_tag} < NUM_TAGS_W);
    assign verdict_cur      = verdict_in_range ? state[verdict_tag] : ST_FREE;
    assign verdict_ok       = verdict_valid & verdict_in_range & (verdict_cur == ST_PENDING)
                              & ~(alloc_gnt & (verdict_tag == alloc_ptr));
    assign verdict_err      = verdict_valid & ~verdict_ok;

    // Head movement frees the tag the buffer just retired; freeing a FREE tag is a protocol error.
    assign head_chg      = (buf_tag != head_prev);
    assign prev_in_range = ({1'b0, head_prev} < NUM_TAGS_W);
    assign prev_state    = prev_in_range ? state[head_prev] : ST_FREE;
    assign reclaim       = head_chg & (prev_state != ST_FREE);
    assign reclaim_err   = head_chg & ~reclaim;

`ifdef REORDER_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE   = TIMEOUT_WIDTH'(1);

    logic [TIMEOUT_WIDTH-1:0] to_cnt;

    assign to_fire = ~head_chg & (head_state == ST_PENDING) & (to_cnt == TO_LIMIT);

    // Watchdog: counts cycles a stable head stays PENDING, pulses once on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= to_fire;
            if (head_chg || (head_state != ST_PENDING) || to_fire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_ONE;
            end
        end
    end
`else
    logic unused_cfg;

    assign to_fire     = 1'b0;
    assign timeout_evt = 1'b0;
    assign unused_cfg  = ^TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
`endif

    // Next tag states; later assignments win (a verdict overrides a forced reject, reclaim overrides all).
    always_comb begin
        state_nxt = state;
        if (alloc_gnt) begin
            state_nxt[alloc_ptr] = ST_PENDING;
        end
        if (to_fire) begin
            state_nxt[buf_tag] = ST_REJECT;
        end
        if (verdict_ok) begin
            state_nxt[verdict_tag] = verdict_accept ? ST_ACCEPT : ST_REJECT;
        end
        if (reclaim) begin
            state_nxt[head_prev] = ST_FREE;
        end
    end

    // Per-tag state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                state[i] <= ST_FREE;
            end
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin allocation pointer and registered head for reclaim detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            head_prev <= '0;
        end else begin
            head_prev <= buf_tag;
            if (alloc_gnt) begin
                alloc_ptr <= (alloc_ptr == LAST_TAG) ? '0 : alloc_ptr + ONE_TAG;
            end
        end
    end

    // Outstanding-tag count; a grant and a reclaim together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            if (alloc_gnt && !reclaim) begin
                outstanding <= outstanding + ONE_CNT;
            end else if (!alloc_gnt && reclaim && !empty) begin
                outstanding <= outstanding - ONE_CNT;
            end
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (verdict_err || reclaim_err) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
